adma_ram_arbiter: RTL and testbench

- Shares the single system-RAM port between three requesters: ADMA descriptor fetch (F), ADMA data transfer (T) and host register/CPU access (H).
- Sits between the ADMA state machine's fetch and transfer engines and the RAM.
- Grants the port in locked bursts with round-robin priority.
- Steers read data back to the requester that issued each read, tracking fixed RAM read latency.

---
 rtl/adma_ram_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_adma_ram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adma_ram_arbiter.sv
// Shares one system-RAM port between ADMA fetch (F), ADMA transfer (T) and host (H)
// using locked round-robin bursts. Read data is steered back to the requester that issued it.

module adma_ram_arbiter_lane #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
) (
    input  logic              own,
    input  logic              req,
    input  logic              write,
    input  logic              last,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              acc,
    output logic              rd,
    output logic              wr,
    output logic              acc_last,
    output logic [ADDR_W-1:0] addr_m,
    output logic [DATA_W-1:0] wdata_m
);
    assign acc      = own & req;
    assign rd       = acc & ~write;
    assign wr       = acc & write;
    assign acc_last = acc & last;
    // Non-owners drive zero, so the top level can OR the lanes together.
    assign addr_m   = own ? addr  : '0;
    assign wdata_m  = own ? wdata : '0;
endmodule

module adma_ram_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int MAX_BURST  = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              f_req,
    input  logic              t_req,
    input  logic              h_req,
    input  logic              f_write,
    input  logic              t_write,
    input  logic              h_write,
    input  logic              f_last,
    input  logic              t_last,
    input  logic              h_last,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic [ADDR_W-1:0] t_addr,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] f_wdata,
    input  logic [DATA_W-1:0] t_wdata,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              f_gnt,
    output logic              t_gnt,
    output logic              h_gnt,
    output logic              f_rvalid,
    output logic              t_rvalid,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read,
    output logic              ram_write,
    output logic [DATA_W-1:0] data_to_ram,
    input  logic [DATA_W-1:0] data_from_ram,
    output logic              busy
);
    localparam int NREQ = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b01,
        ST_GRANT = 2'b10
    } state_t;

    state_t state, state_nxt;
    logic [NREQ-1:0] gnt, gnt_nxt;
    logic [1:0]      rr, rr_nxt;
    logic [7:0]      cnt, cnt_nxt, cnt_inc;
    logic [1:0]      owner, owner_inc;

    logic [RD_LATENCY-1:0]      tag_vld;
    logic [RD_LATENCY-1:0][1:0] tag_own;

    logic [NREQ-1:0]             req, write, last;
    logic [NREQ-1:0]             acc, rd, wr, acc_last, rvalid_v;
    logic [NREQ-1:0][ADDR_W-1:0] addr, addr_m;
    logic [NREQ-1:0][DATA_W-1:0] wdata, wdata_m;

    logic any_acc, cap_hit, others_wait, release_now;

    assign req   = {h_req, t_req, f_req};
    assign write = {h_write, t_write, f_write};
    assign last  = {h_last, t_last, f_last};
    assign addr  = {h_addr, t_addr, f_addr};
    assign wdata = {h_wdata, t_wdata, f_wdata};

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_lane
            adma_ram_arbiter_lane #(
                .ADDR_W(ADDR_W),
                .DATA_W(DATA_W)
            ) u_lane (
                .own      (gnt[i]),
                .req      (req[i]),
                .write    (write[i]),
                .last     (last[i]),
                .addr     (addr[i]),
                .wdata    (wdata[i]),
                .acc      (acc[i]),
                .rd       (rd[i]),
                .wr       (wr[i]),
                .acc_last (acc_last[i]),
                .addr_m   (addr_m[i]),
                .wdata_m  (wdata_m[i])
            );
            assign rvalid_v[i] = tag_vld[RD_LATENCY-1] & (tag_own[RD_LATENCY-1] == 2'(i));
        end
    endgenerate

    always_comb begin
        ram_address = '0;
        data_to_ram = '0;
        for (int i = 0; i < NREQ; i++) begin
            ram_address = ram_address | addr_m[i];
            data_to_ram = data_to_ram | wdata_m[i];
        end
    end

    assign ram_read  = |rd;
    assign ram_write = |wr;

    assign owner       = gnt[1] ? 2'd1 : (gnt[2] ? 2'd2 : 2'd0);
    assign owner_inc   = (owner == 2'd2) ? 2'd0 : owner + 2'd1;
    assign any_acc     = |acc;
    assign cnt_inc     = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    assign cap_hit     = any_acc & (cnt_inc == 8'(MAX_BURST));
    assign others_wait = |(req & ~gnt);
    // An owner that drops req without last gives the port up immediately.
    assign release_now = (|acc_last) | ~(|(req & gnt)) | (cap_hit & others_wait);

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        rr_nxt    = rr;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    state_nxt = ST_GRANT;
                    gnt_nxt   = '0;
                    for (int k = NREQ - 1; k >= 0; k--) begin
                        // Walking down means the lowest rotation offset wins.
                        if (req[(int'(rr) + k) % NREQ]) begin
                            gnt_nxt = '0;
                            gnt_nxt[(int'(rr) + k) % NREQ] = 1'b1;
                        end
                    end
                end
            end
            ST_GRANT: begin
                if (any_acc) cnt_nxt = cnt_inc;
                if (release_now) begin
                    state_nxt = ST_IDLE;
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                    rr_nxt    = owner_inc;
                end else if (cap_hit) begin
                    cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
            gnt   <= '0;
            rr    <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            rr    <= rr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Tag pipeline mirrors the RAM read latency so returns survive grant changes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            tag_vld <= '0;
            tag_own <= '0;
        end else begin
            tag_vld[0] <= ram_read;
            tag_own[0] <= owner;
            for (int s = 1; s < RD_LATENCY; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_own[s] <= tag_own[s-1];
            end
        end
    end

    assign f_gnt    = gnt[0];
    assign t_gnt    = gnt[1];
    assign h_gnt    = gnt[2];
    assign f_rvalid = rvalid_v[0];
    assign t_rvalid = rvalid_v[1];
    assign h_rvalid = rvalid_v[2];
    assign rdata    = data_from_ram;
    assign busy     = (state == ST_GRANT) | (|tag_vld);
endmodule

// File: tb/tb_adma_ram_arbiter.sv
// Directed bench for adma_ram_arbiter: three instances (RD_LATENCY 1, 2, 3) share one
// stimulus stream, and each scenario checks the instance whose latency it targets.

module tb_adma_ram_arbiter;
    localparam int AW = 64;
    localparam int DW = 32;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          RESET;
    logic          f_req, t_req, h_req, f_write, t_write, h_write, f_last, t_last, h_last;
    logic [AW-1:0] f_addr, t_addr, h_addr;
    logic [DW-1:0] f_wdata, t_wdata, h_wdata;

    logic [2:0]    gnt    [3];
    logic [2:0]    rvalid [3];
    logic [DW-1:0] rdata  [3];
    logic [DW-1:0] to_ram [3];
    logic [DW-1:0] from_ram [3];
    logic [AW-1:0] ram_addr [3];
    logic          ram_rd [3];
    logic          ram_wr [3];
    logic          busy   [3];

    adma_ram_arbiter #(.RD_LATENCY(1)) u1 (
        .CLK(CLK), .RESET(RESET),
        .f_req(f_req), .t_req(t_req), .h_req(h_req),
        .f_write(f_write), .t_write(t_write), .h_write(h_write),
        .f_last(f_last), .t_last(t_last), .h_last(h_last),
        .f_addr(f_addr), .t_addr(t_addr), .h_addr(h_addr),
        .f_wdata(f_wdata), .t_wdata(t_wdata), .h_wdata(h_wdata),
        .f_gnt(gnt[0][0]), .t_gnt(gnt[0][1]), .h_gnt(gnt[0][2]),
        .f_rvalid(rvalid[0][0]), .t_rvalid(rvalid[0][1]), .h_rvalid(rvalid[0][2]),
        .rdata(rdata[0]), .ram_address(ram_addr[0]), .ram_read(ram_rd[0]),
        .ram_write(ram_wr[0]), .data_to_ram(to_ram[0]), .data_from_ram(from_ram[0]),
        .busy(busy[0])
    );

    adma_ram_arbiter #(.RD_LATENCY(2)) u2 (
        .CLK(CLK), .RESET(RESET),
        .f_req(f_req), .t_req(t_req), .h_req(h_req),
        .f_write(f_write), .t_write(t_write), .h_write(h_write),
        .f_last(f_last), .t_last(t_last), .h_last(h_last),
        .f_addr(f_addr), .t_addr(t_addr), .h_addr(h_addr),
        .f_wdata(f_wdata), .t_wdata(t_wdata), .h_wdata(h_wdata),
        .f_gnt(gnt[1][0]), .t_gnt(gnt[1][1]), .h_gnt(gnt[1][2]),
        .f_rvalid(rvalid[1][0]), .t_rvalid(rvalid[1][1]), .h_rvalid(rvalid[1][2]),
        .rdata(rdata[1]), .ram_address(ram_addr[1]), .ram_read(ram_rd[1]),
        .ram_write(ram_wr[1]), .data_to_ram(to_ram[1]), .data_from_ram(from_ram[1]),
        .busy(busy[1])
    );

    adma_ram_arbiter #(.RD_LATENCY(3)) u3 (
        .CLK(CLK), .RESET(RESET),
        .f_req(f_req), .t_req(t_req), .h_req(h_req),
        .f_write(f_write), .t_write(t_write), .h_write(h_write),
        .f_last(f_last), .t_last(t_last), .h_last(h_last),
        .f_addr(f_addr), .t_addr(t_addr), .h_addr(h_addr),
        .f_wdata(f_wdata), .t_wdata(t_wdata), .h_wdata(h_wdata),
        .f_gnt(gnt[2][0]), .t_gnt(gnt[2][1]), .h_gnt(gnt[2][2]),
        .f_rvalid(rvalid[2][0]), .t_rvalid(rvalid[2][1]), .h_rvalid(rvalid[2][2]),
        .rdata(rdata[2]), .ram_address(ram_addr[2]), .ram_read(ram_rd[2]),
        .ram_write(ram_wr[2]), .data_to_ram(to_ram[2]), .data_from_ram(from_ram[2]),
        .busy(busy[2])
    );

    // RAM model: contents are the address XOR a fixed pattern, delayed by each latency.
    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 32'hA5A5_0000;
    endfunction

    logic [DW-1:0] p1 = '0;
    logic [DW-1:0] p2 [2] = '{default: '0};
    logic [DW-1:0] p3 [3] = '{default: '0};

    always @(posedge CLK) begin
        p1    <= ram_rd[0] ? mem(ram_addr[0]) : '0;
        p2[0] <= ram_rd[1] ? mem(ram_addr[1]) : '0;
        p2[1] <= p2[0];
        p3[0] <= ram_rd[2] ? mem(ram_addr[2]) : '0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end

    assign from_ram[0] = p1;
    assign from_ram[1] = p2[1];
    assign from_ram[2] = p3[2];

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge CLK);
    endtask

    task automatic clear_in();
        f_req = 0; t_req = 0; h_req = 0;
        f_write = 0; t_write = 0; h_write = 0;
        f_last = 0; t_last = 0; h_last = 0;
        f_addr = '0; t_addr = '0; h_addr = '0;
        f_wdata = '0; t_wdata = '0; h_wdata = '0;
    endtask

    // Leaves the bench at a falling edge after one reset posedge; caller releases RESET.
    task automatic do_reset();
        nxt();
        RESET = 1;
        clear_in();
        nxt();
    endtask

    logic [2:0]  exp_g [7] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    logic [63:0] exp_a [7] = '{64'h10, 64'h0, 64'h20, 64'h0, 64'h30, 64'h0, 64'h10};

    initial begin
        int nrd;
        RESET = 1;
        clear_in();

        // Reset state, then F alone: four reads with last on the fourth.
        do_reset();
        RESET = 0;
        #1;
        chk("rst_gnt", 64'(gnt[0]), 64'(3'b000));
        chk("rst_busy", 64'(busy[0]), 64'(1'b0));
        chk("rst_rd", 64'(ram_rd[0]), 64'(1'b0));
        chk("rst_wr", 64'(ram_wr[0]), 64'(1'b0));
        chk("rst_addr", 64'(ram_addr[0]), 64'h0);
        chk("rst_wdata", 64'(to_ram[0]), 64'h0);
        chk("rst_rvalid", 64'(rvalid[0]), 64'(3'b000));

        nxt(); f_req = 1; f_addr = 64'h100;
        #1;
        chk("t1_gnt_wait", 64'(gnt[0]), 64'(3'b000));
        chk("t1_rd_wait", 64'(ram_rd[0]), 64'(1'b0));
        for (int i = 0; i < 4; i++) begin
            nxt(); f_addr = 64'(32'h100 + 4 * i); f_last = (i == 3);
            #1;
            chk("t1_gnt", 64'(gnt[0]), 64'(3'b001));
            chk("t1_rd", 64'(ram_rd[0]), 64'(1'b1));
            chk("t1_addr", 64'(ram_addr[0]), 64'(32'h100 + 4 * i));
            chk("t1_rvalid", 64'(rvalid[0]), (i > 0) ? 64'(3'b001) : 64'(3'b000));
            if (i > 0) chk("t1_rdata", 64'(rdata[0]), 64'(32'hA5A5_0100 + 4 * (i - 1)));
        end
        nxt(); f_req = 0; f_last = 0;
        #1;
        chk("t1_gnt_drop", 64'(gnt[0]), 64'(3'b000));
        chk("t1_rd_drop", 64'(ram_rd[0]), 64'(1'b0));
        chk("t1_rvalid_last", 64'(rvalid[0]), 64'(3'b001));
        chk("t1_rdata_last", 64'(rdata[0]), 64'h0000_0000_A5A5_010C);
        chk("t1_busy_tail", 64'(busy[0]), 64'(1'b1));
        nxt();
        #1;
        chk("t1_rvalid_end", 64'(rvalid[0]), 64'(3'b000));
        chk("t1_busy_end", 64'(busy[0]), 64'(1'b0));

        // rr pointer now T: F and T together must pick T, then F.
        nxt(); f_req = 1; t_req = 1; f_last = 1; t_last = 1; t_addr = 64'h180;
        #1;
        chk("t1_rr_idle", 64'(gnt[0]), 64'(3'b000));
        nxt();
        #1;
        chk("t1_rr_T", 64'(gnt[0]), 64'(3'b010));
        nxt(); t_req = 0;
        #1;
        chk("t1_rr_gap", 64'(gnt[0]), 64'(3'b000));
        chk("t1_T_rvalid", 64'(rvalid[0]), 64'(3'b010));
        chk("t1_T_rdata", 64'(rdata[0]), 64'h0000_0000_A5A5_0180);
        nxt();
        #1;
        chk("t1_rr_F", 64'(gnt[0]), 64'(3'b001));
        nxt(); f_req = 0; f_last = 0; t_last = 0;
        #1;
        chk("t1_rr_done", 64'(gnt[0]), 64'(3'b000));

        // All three request from reset with one-access bursts.
        do_reset();
        RESET = 0; f_req = 1; t_req = 1; h_req = 1; f_last = 1; t_last = 1; h_last = 1;
        f_addr = 64'h10; t_addr = 64'h20; h_addr = 64'h30;
        #1;
        chk("t2_gnt_wait", 64'(gnt[0]), 64'(3'b000));
        for (int i = 0; i < 7; i++) begin
            nxt();
            #1;
            chk("t2_gnt", 64'(gnt[0]), 64'(exp_g[i]));
            chk("t2_addr", 64'(ram_addr[0]), exp_a[i]);
        end
        nxt(); clear_in();
        #1;
        chk("t2_done", 64'(gnt[0]), 64'(3'b000));

        // T streams reads with H waiting: forced release after MAX_BURST accesses.
        do_reset();
        RESET = 0; t_req = 1; t_addr = 64'h300; h_req = 1; h_last = 1; h_addr = 64'h400;
        #1;
        chk("t3_gnt_wait", 64'(gnt[0]), 64'(3'b000));
        for (int i = 0; i < 8; i++) begin
            nxt();
            #1;
            chk("t3_T_gnt", 64'(gnt[0]), 64'(3'b010));
            chk("t3_T_rd", 64'(ram_rd[0]), 64'(1'b1));
        end
        nxt();
        #1;
        chk("t3_T_release", 64'(gnt[0]), 64'(3'b000));
        chk("t3_gap_rd", 64'(ram_rd[0]), 64'(1'b0));
        nxt();
        #1;
        chk("t3_H_gnt", 64'(gnt[0]), 64'(3'b100));
        chk("t3_H_addr", 64'(ram_addr[0]), 64'h400);
        nxt(); h_req = 0; h_last = 0;
        #1;
        chk("t3_H_release", 64'(gnt[0]), 64'(3'b000));
        nxt();
        #1;
        chk("t3_T_regain", 64'(gnt[0]), 64'(3'b010));
        nxt(); t_req = 0;
        #1;
        chk("t3_T_noreq_gnt", 64'(gnt[0]), 64'(3'b010));
        chk("t3_T_noreq_rd", 64'(ram_rd[0]), 64'(1'b0));
        nxt();
        #1;
        chk("t3_done", 64'(gnt[0]), 64'(3'b000));

        // T alone for 20 reads: burst cap hit twice but never releases.
        do_reset();
        RESET = 0; t_req = 1; t_addr = 64'h500;
        #1;
        nrd = 0;
        for (int i = 0; i < 20; i++) begin
            nxt();
            #1;
            chk("t4_gnt", 64'(gnt[0]), 64'(3'b010));
            if (ram_rd[0]) nrd++;
        end
        chk("t4_rd_count", 64'(nrd), 64'd20);
        nxt(); t_req = 0;
        #1;
        chk("t4_stop_rd", 64'(ram_rd[0]), 64'(1'b0));

        // RD_LATENCY 3: F read, then T write while F's data is in flight.
        do_reset();
        RESET = 0; f_req = 1; f_addr = 64'h200; f_last = 1;
        t_req = 1; t_write = 1; t_addr = 64'h280; t_wdata = 32'hDEAD_BEEF; t_last = 1;
        #1;
        chk("t5_gnt_wait", 64'(gnt[2]), 64'(3'b000));
        nxt();
        #1;
        chk("t5_F_gnt", 64'(gnt[2]), 64'(3'b001));
        chk("t5_F_rd", 64'(ram_rd[2]), 64'(1'b1));
        chk("t5_F_addr", 64'(ram_addr[2]), 64'h200);
        nxt(); f_req = 0; f_last = 0;
        #1;
        chk("t5_gap_gnt", 64'(gnt[2]), 64'(3'b000));
        chk("t5_rvalid_1", 64'(rvalid[2]), 64'(3'b000));
        nxt();
        #1;
        chk("t5_T_gnt", 64'(gnt[2]), 64'(3'b010));
        chk("t5_T_wr", 64'(ram_wr[2]), 64'(1'b1));
        chk("t5_T_nord", 64'(ram_rd[2]), 64'(1'b0));
        chk("t5_T_addr", 64'(ram_addr[2]), 64'h280);
        chk("t5_T_wdata", 64'(to_ram[2]), 64'h0000_0000_DEAD_BEEF);
        chk("t5_rvalid_2", 64'(rvalid[2]), 64'(3'b000));
        nxt(); clear_in();
        #1;
        chk("t5_F_rvalid", 64'(rvalid[2]), 64'(3'b001));
        chk("t5_F_rdata", 64'(rdata[2]), 64'h0000_0000_A5A5_0200);
        nxt();
        #1;
        chk("t5_rvalid_end", 64'(rvalid[2]), 64'(3'b000));
        chk("t5_busy_end", 64'(busy[2]), 64'(1'b0));

        // RD_LATENCY 2: reset one cycle after a read issues discards it.
        do_reset();
        RESET = 0; h_req = 1; h_addr = 64'h600;
        #1;
        nxt();
        #1;
        chk("t6_H_gnt", 64'(gnt[1]), 64'(3'b100));
        chk("t6_H_rd", 64'(ram_rd[1]), 64'(1'b1));
        nxt(); RESET = 1;
        #1;
        chk("t6_rvalid_pre", 64'(rvalid[1]), 64'(3'b000));
        nxt(); RESET = 0;
        #1;
        chk("t6_rst_gnt", 64'(gnt[1]), 64'(3'b000));
        chk("t6_rst_busy", 64'(busy[1]), 64'(1'b0));
        chk("t6_rst_rd", 64'(ram_rd[1]), 64'(1'b0));
        chk("t6_rst_wr", 64'(ram_wr[1]), 64'(1'b0));
        chk("t6_rst_rvalid", 64'(rvalid[1]), 64'(3'b000));
        nxt();
        #1;
        chk("t6_regrant", 64'(gnt[1]), 64'(3'b100));
        chk("t6_rvalid_gone", 64'(rvalid[1]), 64'(3'b000));
        nxt(); h_req = 0;
        #1;
        chk("t6_rvalid_wait", 64'(rvalid[1]), 64'(3'b000));
        nxt();
        #1;
        chk("t6_fresh_rvalid", 64'(rvalid[1]), 64'(3'b100));
        chk("t6_fresh_rdata", 64'(rdata[1]), 64'h0000_0000_A5A5_0600);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
